req_ack_responder: RTL and testbench

// - Responder end of the 4-phase req/ack clock-crossing handshake.
// - Samples an initiator's req from a foreign clock domain through a 2-flop synchronizer.
// - Fetches one word from a local source and presents it as a one-cycle data_valid pulse.
// - Asserts ack on the following cycle and holds it until req falls.
// - Sits on the local-clock side of every req -> data_valid -> ack crossing.

---
 rtl/req_ack_pkg.sv | 4 +
 rtl/sync_2ff.sv | 19 +
 rtl/req_ack_responder.sv | 98 +++++++++
 tb/tb_req_ack_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// Shared types for the responder side of the req/ack clock-crossing handshake.
package req_ack_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DATA, ACK} resp_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer, reset to 0. Also used by the initiator for ack.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/req_ack_responder.sv
// Responder end of a 4-phase req/ack handshake: synchronizes req, returns one
// local word as a data_valid pulse, then holds ack until req falls or times out.
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RESP_DLY = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [DATA_W-1:0] src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic              ack,
   output logic              busy,
   output logic              abort_seen,
   output logic              timeout_err
);
   localparam int DW = (RESP_DLY > 0) ? $clog2(RESP_DLY + 1) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   resp_state_t   state, state_nxt;
   logic          req_s, req_s_q, req_rise;
   logic [1:0]    settle;
   logic [DW-1:0] dly_cnt;
   logic [TW-1:0] to_cnt;
   logic          dly_done, to_hit;

   sync_2ff u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (req),
      .q   (req_s)
   );

   // Edge detect is held off until the synchronizer and req_s_q have refilled
   // after reset, so a req already high through reset never looks like a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_s_q <= 1'b0;
         settle  <= 2'd0;
      end else begin
         req_s_q <= req_s;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   assign req_rise = req_s & ~req_s_q & (settle == 2'd3);
   assign dly_done = (dly_cnt >= DW'(RESP_DLY));
   assign to_hit   = (to_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_rise) state_nxt = WAIT;
         WAIT: begin
            if (!req_s)                      state_nxt = IDLE;
            else if (dly_done && src_valid)  state_nxt = DATA;
         end
         DATA: state_nxt = ACK;
         ACK:  if (!req_s || to_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dly_cnt     <= '0;
         to_cnt      <= '0;
         data        <= '0;
         abort_seen  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == IDLE) begin
            dly_cnt <= '0;
            to_cnt  <= '0;
         end else begin
            if (state == WAIT && !dly_done) dly_cnt <= dly_cnt + DW'(1);
            if (state == ACK && !to_hit)    to_cnt  <= to_cnt + TW'(1);
         end
         // Word is loaded on entry to DATA so it is already valid during the strobe.
         if (state == WAIT && state_nxt == DATA) data <= src_data;
         if (state == WAIT && !req_s)           abort_seen  <= 1'b1;
         if (state == ACK && req_s && to_hit)   timeout_err <= 1'b1;
      end
   end

   assign data_valid = (state == DATA);
   assign src_ready  = (state == DATA);
   assign ack        = (state == ACK);
   assign busy       = (state != IDLE);
endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder with a scoreboard queue of expected words.
module tb_req_ack_responder;
   localparam int DATA_W   = 8;
   localparam int RESP_DLY = 2;
   localparam int TIMEOUT  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req = 1'b0;
   logic [DATA_W-1:0] src_data = '0;
   logic              src_valid = 1'b0;
   logic              src_ready, data_valid, ack, busy, abort_seen, timeout_err;
   logic [DATA_W-1:0] data;

   int                checks = 0;
   int                errors = 0;
   int                dv_cnt = 0;
   int                rdy_cnt = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic              prev_dv = 1'b0;
   logic              prev_ack = 1'b0;

   req_ack_responder #(.DATA_W(DATA_W), .RESP_DLY(RESP_DLY), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .data        (data),
      .data_valid  (data_valid),
      .ack         (ack),
      .busy        (busy),
      .abort_seen  (abort_seen),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack(input logic v, input int lim, output int n);
      n = 0;
      while (ack !== v && n < lim) begin
         tick();
         n++;
      end
      if (ack !== v) begin
         checks++;
         errors++;
         $display("FAIL wait_ack got %0b expected %0b within %0d cycles", ack, v, lim);
      end
   endtask

   // Monitor: pops the scoreboard on every data_valid and checks strobe ordering.
   always @(negedge clk) begin
      if (rst) begin
         prev_dv  = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (data_valid) begin
            dv_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_data_valid got data %0h expected none", data);
            end else begin
               chk("data", int'(data), int'(exp_q.pop_front()));
            end
            chk("src_ready_with_dv", int'(src_ready), 1);
         end else if (src_ready) begin
            chk("src_ready_without_dv", int'(src_ready), 0);
         end
         if (src_ready) rdy_cnt++;
         if (prev_dv) chk("ack_after_dv", int'(ack), 1);
         if (ack && !prev_ack) chk("ack_rise_needs_dv", int'(prev_dv), 1);
         prev_dv  = data_valid;
         prev_ack = ack;
      end
   end

   task automatic txn(input logic [DATA_W-1:0] d);
      int n;
      src_data  = d;
      src_valid = 1'b1;
      exp_q.push_back(d);
      req = 1'b1;
      wait_ack(1'b1, 40, n);
      tick(2);
      chk("ack_held", int'(ack), 1);
      chk("data_during_ack", int'(data), int'(d));
      req = 1'b0;
      wait_ack(1'b0, 10, n);
      chk("ack_fall_latency", int'(n >= 3 && n <= 4), 1);
      chk("busy_after_txn", int'(busy), 0);
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, d0, r0;
      rst = 1'b1;
      tick(3);
      chk("reset_outputs", int'({ack, busy, data_valid, src_ready, abort_seen, timeout_err, data}), 0);
      rst = 1'b0;
      tick(4);

      // basic
      txn(8'hA5);
      chk("data_hold_A5", int'(data), 8'hA5);

      // stall: source empty for 10 cycles after req
      src_valid = 1'b0;
      src_data  = 8'h3C;
      d0 = dv_cnt;
      exp_q.push_back(8'h3C);
      req = 1'b1;
      tick(10);
      chk("stall_no_dv", dv_cnt - d0, 0);
      chk("stall_busy", int'(busy), 1);
      src_valid = 1'b1;
      wait_ack(1'b1, 20, n);
      chk("stall_one_dv", dv_cnt - d0, 1);
      req = 1'b0;
      wait_ack(1'b0, 10, n);
      tick(2);

      // abort: req drops shortly after WAIT is reached
      src_valid = 1'b0;
      d0 = dv_cnt;
      req = 1'b1;
      n = 0;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      chk("abort_enter_wait", int'(busy), 1);
      tick();
      req = 1'b0;
      tick(5);
      chk("abort_seen", int'(abort_seen), 1);
      chk("abort_idle", int'(busy), 0);
      chk("abort_no_ack", int'(ack), 0);
      chk("abort_no_dv", dv_cnt - d0, 0);

      // timeout: req held after ack
      src_valid = 1'b1;
      src_data  = 8'h5A;
      exp_q.push_back(8'h5A);
      req = 1'b1;
      wait_ack(1'b1, 40, n);
      n = 1;
      repeat (20) begin
         tick();
         if (!ack) break;
         n++;
      end
      chk("ack_high_cycles", n, TIMEOUT);
      chk("timeout_err", int'(timeout_err), 1);
      chk("timeout_idle", int'(busy), 0);
      req = 1'b0;
      tick(4);
      txn(8'h77);
      chk("timeout_err_sticky", int'(timeout_err), 1);

      // reset while ack is high, req held high across reset
      src_data = 8'h99;
      exp_q.push_back(8'h99);
      req = 1'b1;
      wait_ack(1'b1, 40, n);
      tick();
      rst = 1'b1;
      tick();
      chk("midack_reset_outputs", int'({ack, busy, data_valid, src_ready, abort_seen, timeout_err, data}), 0);
      rst = 1'b0;
      d0 = dv_cnt;
      tick(12);
      chk("no_restart_busy", int'(busy), 0);
      chk("no_restart_dv", dv_cnt - d0, 0);
      req = 1'b0;
      tick(4);

      // back-to-back
      r0 = rdy_cnt;
      txn(8'h11);
      chk("data_hold_11", int'(data), 8'h11);
      txn(8'h22);
      chk("data_22", int'(data), 8'h22);
      chk("src_ready_pulses", rdy_cnt - r0, 2);

      tick(2);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
